// File: rtl/adc_scan_pkg.sv
// Shared definitions for the serial ADC scan controller: FSM encoding,
// default parameter values and the per-channel ADC control words.
package adc_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_FRAME  = 2'd2,
        S_GAP    = 2'd3
    } scan_state_e;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DATA_W     = 10;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_GAP_CYC    = 2;

    localparam logic [15:0] CTRL_WORD_CH0 = 16'h6480;
    localparam logic [15:0] CTRL_WORD_CH1 = 16'h6680;
    localparam logic [15:0] CTRL_WORD_CH2 = 16'h6080;
    localparam logic [15:0] CTRL_WORD_CH3 = 16'h6280;

    // Packed so channel i sits at [i*16 +: 16].
    localparam logic [63:0] DEF_CTRL_WORDS =
        {CTRL_WORD_CH3, CTRL_WORD_CH2, CTRL_WORD_CH1, CTRL_WORD_CH0};

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// Sample delivery bus from the scan controller to the downstream sample buffer.
interface adc_scan_ctrl_if
    import adc_scan_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_W   = $clog2(DEF_NUM_CH)
);

    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;

    modport master (
        output sample_data,
        output sample_ch,
        output sample_valid
    );

    modport slave (
        input sample_data,
        input sample_ch,
        input sample_valid
    );

endinterface

// File: rtl/adc_bit_timer.sv
// SCLK divider and bit counter for one serial frame; starts on start_i and
// stops by itself after FRAME_BITS periods of 2*CLK_DIV cycles.
module adc_bit_timer
    import adc_scan_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1
) (
    input  logic             clk_clk,
    input  logic             reset_n,
    input  logic             start_i,
    output logic             sclk_o,
    output logic             launch_o,
    output logic             sample_o,
    output logic             frame_last_o,
    output logic [BIT_W-1:0] bit_cnt_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             active_q, active_d;
    logic             sclk_q, sclk_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             div_end;

    assign div_end      = (div_q == '0);
    assign sample_o     = active_q & sclk_q & div_end;
    assign frame_last_o = active_q & ~sclk_q & div_end & (bit_q == '0);
    // Asserted in the cycle before a new bit period begins.
    assign launch_o     = start_i | (active_q & ~sclk_q & div_end & (bit_q != '0));
    assign sclk_o       = sclk_q;
    assign bit_cnt_o    = bit_q;

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        div_d    = div_q;
        bit_d    = bit_q;
        if (start_i) begin
            active_d = 1'b1;
            sclk_d   = 1'b1;
            div_d    = DIV_W'(CLK_DIV - 1);
            bit_d    = BIT_W'(FRAME_BITS - 1);
        end else if (active_q) begin
            if (div_end) begin
                div_d = DIV_W'(CLK_DIV - 1);
                if (sclk_q) begin
                    sclk_d = 1'b0;
                end else if (bit_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    sclk_d = 1'b1;
                    bit_d  = bit_q - BIT_W'(1);
                end
            end else begin
                div_d = div_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin serial ADC scan controller: one framed transfer per enabled
// channel, result delivered as a one-cycle strobe tagged with the channel.
//
// state  | meaning
// IDLE   | waiting for enable with a non-empty channel mask
// SELECT | pick next masked-in channel after the pointer, latch its word
// FRAME  | FRAME_BITS SCLK periods, RFS high / TFS low
// GAP    | GAP_CYC quiet cycles, result strobed on the first
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int GAP_CYC    = DEF_GAP_CYC
) (
    input  logic                         clk_clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [NUM_CH*FRAME_BITS-1:0] ctrl_words,
    input  logic                         SPI_IN,
    output logic                         SPI_OUT,
    output logic                         SCLK,
    output logic                         RFS,
    output logic                         TFS,
    output logic                         busy,
    adc_scan_ctrl_if.master              smp_if
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    scan_state_e           state_q, state_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]     rx_q, rx_d;
    logic                  spi_out_q, spi_out_d;
    logic                  rfs_q, tfs_q, busy_q;
    logic [DATA_W-1:0]     smp_data_q, smp_data_d;
    logic [CH_W-1:0]       smp_ch_q, smp_ch_d;
    logic                  smp_valid_q, smp_valid_d;

    logic                  scan_req;
    logic                  sel_found;
    logic [CH_W-1:0]       sel_ch, cand;
    logic [FRAME_BITS-1:0] sel_word;
    logic                  timer_start;
    logic                  launch, sample, frame_last;
    logic [BIT_W-1:0]      bit_cnt;

    assign scan_req = enable & (|ch_mask);
    assign sel_word = ctrl_words[int'(sel_ch)*FRAME_BITS +: FRAME_BITS];

    adc_bit_timer #(
        .FRAME_BITS (FRAME_BITS),
        .CLK_DIV    (CLK_DIV),
        .BIT_W      (BIT_W)
    ) u_timer (
        .clk_clk      (clk_clk),
        .reset_n      (reset_n),
        .start_i      (timer_start),
        .sclk_o       (SCLK),
        .launch_o     (launch),
        .sample_o     (sample),
        .frame_last_o (frame_last),
        .bit_cnt_o    (bit_cnt)
    );

    // First set mask bit strictly after the pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = ptr_q;
        cand      = ptr_q;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
            if (!sel_found && ch_mask[cand]) begin
                sel_found = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gap_d       = gap_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        spi_out_d   = spi_out_q;
        smp_data_d  = smp_data_q;
        smp_ch_d    = smp_ch_q;
        smp_valid_d = 1'b0;
        timer_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scan_req) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (sel_found) begin
                    state_d     = S_FRAME;
                    ptr_d       = sel_ch;
                    timer_start = 1'b1;
                    spi_out_d   = sel_word[FRAME_BITS-1];
                    tx_d        = sel_word << 1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FRAME: begin
                if (launch) begin
                    spi_out_d = tx_q[FRAME_BITS-1];
                    tx_d      = tx_q << 1;
                end
                // Only the leading DATA_W bits of the frame carry the result.
                if (sample && (int'(bit_cnt) >= FRAME_BITS - DATA_W)) begin
                    rx_d = DATA_W'({rx_q, SPI_IN});
                end
                if (frame_last) begin
                    state_d     = S_GAP;
                    gap_d       = GAP_W'(GAP_CYC - 1);
                    spi_out_d   = 1'b0;
                    smp_valid_d = 1'b1;
                    smp_data_d  = rx_q;
                    smp_ch_d    = ptr_q;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = scan_req ? S_SELECT : S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= CH_W'(NUM_CH - 1);
            gap_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            spi_out_q   <= 1'b0;
            rfs_q       <= 1'b0;
            tfs_q       <= 1'b1;
            busy_q      <= 1'b0;
            smp_data_q  <= '0;
            smp_ch_q    <= '0;
            smp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gap_q       <= gap_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            spi_out_q   <= spi_out_d;
            rfs_q       <= (state_d == S_FRAME);
            tfs_q       <= (state_d != S_FRAME);
            busy_q      <= (state_d != S_IDLE);
            smp_data_q  <= smp_data_d;
            smp_ch_q    <= smp_ch_d;
            smp_valid_q <= smp_valid_d;
        end
    end

    assign SPI_OUT             = spi_out_q;
    assign RFS                 = rfs_q;
    assign TFS                 = tfs_q;
    assign busy                = busy_q;
    assign smp_if.sample_data  = smp_data_q;
    assign smp_if.sample_ch    = smp_ch_q;
    assign smp_if.sample_valid = smp_valid_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl: ADC model, round-robin scoreboard and
// per-cycle frame waveform checks.
module tb_adc_scan_ctrl;
    import adc_scan_pkg::*;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 10;
    localparam int FRAME_BITS = 16;
    localparam int CLK_DIV    = 2;
    localparam int GAP_CYC    = 2;
    localparam int CH_W       = 2;
    localparam int FRAME_CYC  = FRAME_BITS * 2 * CLK_DIV;

    logic        clk_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [63:0] ctrl_words;
    logic        spi_in;
    logic        spi_out, sclk, rfs, tfs, busy;

    adc_scan_ctrl_if #(.DATA_W(DATA_W), .CH_W(CH_W)) smp ();

    adc_scan_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS),
        .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .ch_mask    (ch_mask),
        .ctrl_words (ctrl_words),
        .SPI_IN     (spi_in),
        .SPI_OUT    (spi_out),
        .SCLK       (sclk),
        .RFS        (rfs),
        .TFS        (tfs),
        .busy       (busy),
        .smp_if     (smp)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         ch;
        logic [9:0] data;
    } exp_t;

    exp_t        sb[$];
    int          ch_log[$];
    logic [9:0]  data_log[$];
    int          valid_cyc[$];
    int          start_cyc[$];
    int          busy_rise[$];
    logic [15:0] adc_word;
    logic [15:0] cur_adc, cur_ctrl;
    logic [3:0]  mask_prev = 4'h0;
    logic        busy_prev = 1'b0;
    bit          in_frame = 1'b0;
    int          cyc = 0;
    int          fc, k, ph, mch, midx;
    int          model_ptr = NUM_CH - 1;
    exp_t        e;

    // Monitor, ADC model and scoreboard, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk_clk);
            cyc++;
            if (reset_n !== 1'b1) begin
                sb.delete();
                model_ptr = NUM_CH - 1;
                in_frame  = 1'b0;
            end else begin
                if (rfs === 1'b1 && !in_frame) begin
                    chk("select_mask_nonzero", (mask_prev != 4'h0), 1);
                    mch = -1;
                    for (int i = 1; i <= NUM_CH; i++) begin
                        midx = (model_ptr + i) % NUM_CH;
                        if (mch < 0 && mask_prev[midx]) mch = midx;
                    end
                    if (mch < 0) mch = 0;
                    model_ptr = mch;
                    in_frame  = 1'b1;
                    fc        = 0;
                    cur_adc   = adc_word;
                    cur_ctrl  = ctrl_words[mch*16 +: 16];
                    e.ch      = mch;
                    e.data    = cur_adc[15:6];
                    sb.push_back(e);
                    start_cyc.push_back(cyc);
                end
                if (in_frame) begin
                    if (fc < FRAME_CYC) begin
                        k  = fc / (2 * CLK_DIV);
                        ph = fc % (2 * CLK_DIV);
                        chk("frame_rfs", rfs, 1);
                        chk("frame_tfs", tfs, 0);
                        chk("frame_sclk", sclk, (ph < CLK_DIV) ? 1 : 0);
                        if (ph == 0) chk("spi_out_bit", spi_out, cur_ctrl[15-k]);
                        // Correct bit only during the last high cycle.
                        spi_in = (ph == CLK_DIV - 1) ? cur_adc[15-k] : ~cur_adc[15-k];
                        fc++;
                    end else begin
                        chk("frame_end_rfs", rfs, 0);
                        in_frame = 1'b0;
                        spi_in   = 1'b1;
                    end
                end
                if (!in_frame) begin
                    chk("idle_sclk", sclk, 0);
                    chk("idle_spi_out", spi_out, 0);
                    chk("idle_tfs", tfs, 1);
                end
                if (smp.sample_valid === 1'b1) begin
                    chk("sb_nonempty", (sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("sample_ch", smp.sample_ch, e.ch);
                        chk("sample_data", smp.sample_data, e.data);
                    end
                    ch_log.push_back(int'(smp.sample_ch));
                    data_log.push_back(smp.sample_data);
                    valid_cyc.push_back(cyc);
                end
                if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise.push_back(cyc);
            end
            mask_prev = ch_mask;
            busy_prev = busy;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_clk);
        #1;
    endtask

    task automatic wait_valids(input int n, input int budget);
        int target;
        bit ok;
        target = ch_log.size() + n;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            at_neg();
            if (ch_log.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_valids", ok, 1);
    endtask

    task automatic wait_frame(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            at_neg();
            if (rfs === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_frame", ok, 1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rfs"}, rfs, 0);
        chk({tag, "_tfs"}, tfs, 1);
        chk({tag, "_sclk"}, sclk, 0);
        chk({tag, "_spi_out"}, spi_out, 0);
        chk({tag, "_valid"}, smp.sample_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    int exp_seq1[5] = '{0, 1, 2, 3, 0};
    int exp_seq2[4] = '{1, 3, 1, 3};
    int n0, s0;

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        ch_mask    = 4'h0;
        ctrl_words = DEF_CTRL_WORDS;
        spi_in     = 1'b0;
        adc_word   = 16'hB2C0;
        repeat (4) step();
        at_neg();
        chk_quiet("reset");
        chk("reset_data", smp.sample_data, 0);
        chk("reset_ch", smp.sample_ch, 0);
        step();
        reset_n = 1'b1;

        // Full mask: 0,1,2,3,0 with fixed frame timing.
        step();
        enable  = 1'b1;
        ch_mask = 4'hF;
        wait_valids(5, 400);
        for (int i = 0; i < 5; i++) chk("seq_full_mask", ch_log[i], exp_seq1[i]);
        chk("first_data", data_log[0], 10'h2CB);
        chk("select_to_valid", valid_cyc[0] - busy_rise[0], 65);
        chk("start_to_valid", valid_cyc[0] - start_cyc[0], 64);
        for (int i = 0; i < 4; i++) chk("select_period", start_cyc[i+1] - start_cyc[i], 67);

        // Sparse mask; low ADC bits set to show they are ignored.
        step();
        ch_mask  = 4'hA;
        adc_word = 16'h4D3F;
        wait_valids(4, 400);
        for (int i = 0; i < 4; i++) chk("seq_mask_1010", ch_log[5+i], exp_seq2[i]);
        chk("data_ignores_tail", data_log[5], 10'h134);

        // Empty mask with enable high: controller parks in IDLE.
        step();
        ch_mask = 4'h0;
        repeat (10) step();
        at_neg();
        chk_quiet("empty_mask");
        n0 = ch_log.size();
        repeat (100) step();
        chk("empty_mask_no_valid", ch_log.size(), n0);

        // enable dropped mid-frame: frame completes, then IDLE.
        adc_word = 16'hB2C0;
        ch_mask  = 4'hF;
        wait_frame(20);
        repeat (20) step();
        enable = 1'b0;
        n0 = ch_log.size();
        wait_valids(1, 200);
        chk("drop_enable_ch", ch_log[n0], 0);
        chk("drop_enable_data", data_log[n0], 10'h2CB);
        at_neg();
        chk("drop_enable_gap_busy", busy, 1);
        at_neg();
        chk("drop_enable_idle_busy", busy, 0);
        s0 = start_cyc.size();
        repeat (60) step();
        chk("drop_enable_no_frame", start_cyc.size(), s0);
        chk("drop_enable_no_valid", ch_log.size(), n0 + 1);

        // Reset mid-frame aborts without a strobe; scan restarts at channel 0.
        enable = 1'b1;
        wait_frame(20);
        repeat (30) step();
        reset_n = 1'b0;
        n0 = ch_log.size();
        step();
        at_neg();
        chk_quiet("abort");
        chk("abort_data", smp.sample_data, 0);
        step();
        step();
        reset_n = 1'b1;
        wait_valids(1, 300);
        chk("abort_valid_count", ch_log.size(), n0 + 1);
        chk("restart_ch", ch_log[n0], 0);

        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
